// File: rtl/quad_decoder_pkg.sv
// Shared definitions for the quadrature decoder.
// Holds the {A,B} quadrature state encodings, the decoder FSM state
// constants, the default speed window for a 125 MHz clock and the
// transition classifier used by the decoder.
package quad_decoder_pkg;

    // Quadrature states written as {A,B}; forward order is S00->S10->S11->S01
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    // Decoder FSM states
    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    // Speed window counter width and the 100 ms gate at 125 MHz (length minus one)
    localparam int unsigned   WINDOW_WIDTH        = 27;
    localparam logic [26:0]   SPEED_WINDOW_125MHZ = 27'd12499999;

    // Classification of one previous->current quadrature transition
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    // Any single-bit change is either the forward successor or, failing that, a reverse step
    function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t step;
        step = STEP_NONE;
        if (prev != cur) begin
            if ((prev ^ cur) == 2'b11) begin
                step = STEP_ILLEGAL;
            end else begin
                case (prev)
                    S00:     step = (cur == S10) ? STEP_FWD : STEP_REV;
                    S10:     step = (cur == S11) ? STEP_FWD : STEP_REV;
                    S11:     step = (cur == S01) ? STEP_FWD : STEP_REV;
                    default: step = (cur == S00) ? STEP_FWD : STEP_REV;
                endcase
            end
        end
        return step;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a persistence filter for one encoder pin.
// A change on the synchronised pin is accepted only after it has differed from
// the filtered value on FILTER_LEN consecutive cycles.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   pin      - raw asynchronous encoder input
//   filtered - filtered pin level (registered)
//   quiet_c  - no pending change anywhere in the sync/filter chain (combinational)
module quad_input_filter #(
    parameter logic [3:0] FILTER_LEN = 4'd8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filtered,
    output logic quiet_c
);

    localparam int unsigned CNT_WIDTH = 4;

    logic                 meta_q;
    logic                 sync_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 filt_d;

    // Filter next state: count disagreeing cycles, accept on the FILTER_LEN-th
    always_comb begin
        cnt_d  = '0;
        filt_d = filtered;
        if (sync_q != filtered) begin
            if (cnt_q == FILTER_LEN - 4'd1) begin
                filt_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Synchroniser and filter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            cnt_q    <= '0;
            filtered <= 1'b0;
        end else begin
            meta_q   <= pin;
            sync_q   <= meta_q;
            cnt_q    <= cnt_d;
            filtered <= filt_d;
        end
    end

    // Both sync stages agree with the filtered level, so nothing is in flight
    assign quiet_c = (meta_q == filtered) && (sync_q == filtered);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder reader for one motor channel.
// Filters ENC_A/ENC_B, decodes them at 4x resolution into a wrapping signed
// POSITION, tracks DIR, flags illegal double transitions on ERR and, when
// QUAD_SPEED_EN is defined, reports edges per SPEED_WINDOW+1 cycles on SPEED.
// Configuration macro: QUAD_SPEED_EN (undefined: SPEED=0, SPEED_VALID=0).
// Ports:
//   CLK         - system clock, rising edge
//   RST         - synchronous active-high reset
//   ENC_A/ENC_B - asynchronous encoder channels
//   CLR         - synchronous clear of POSITION and ERR
//   POSITION    - signed wrapping edge count
//   DIR         - 1 = last counted edge forward, 0 = reverse
//   SPEED       - signed edge count of the last complete window
//   SPEED_VALID - one-cycle pulse when SPEED updates
//   ERR         - sticky illegal-transition flag
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int unsigned              POS_WIDTH    = 16,
    parameter logic [3:0]               FILTER_LEN   = 4'd8,
    parameter logic [WINDOW_WIDTH-1:0]  SPEED_WINDOW = SPEED_WINDOW_125MHZ
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENC_A,
    input  logic                 ENC_B,
    input  logic                 CLR,
    output logic [POS_WIDTH-1:0] POSITION,
    output logic                 DIR,
    output logic [POS_WIDTH-1:0] SPEED,
    output logic                 SPEED_VALID,
    output logic                 ERR
);

    localparam int unsigned CNT_WIDTH = 4;

    logic                 a_filt;
    logic                 b_filt;
    logic                 a_quiet_c;
    logic                 b_quiet_c;
    logic [1:0]           cur;

    logic [0:0]           state_q;
    logic [0:0]           state_d;
    logic [1:0]           prev_q;
    logic [1:0]           prev_d;
    logic [CNT_WIDTH-1:0] prime_cnt_q;
    logic [CNT_WIDTH-1:0] prime_cnt_d;
    logic [POS_WIDTH-1:0] pos_d;
    logic                 dir_d;
    logic                 err_d;
    step_t                step;

    quad_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter_a (
        .clk      (CLK),
        .rst      (RST),
        .pin      (ENC_A),
        .filtered (a_filt),
        .quiet_c  (a_quiet_c)
    );

    quad_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter_b (
        .clk      (CLK),
        .rst      (RST),
        .pin      (ENC_B),
        .filtered (b_filt),
        .quiet_c  (b_quiet_c)
    );

    assign cur = {a_filt, b_filt};

    // Decoder next state: PRIME waits for quiet inputs, RUN counts transitions
    always_comb begin
        state_d     = state_q;
        prev_d      = cur;
        prime_cnt_d = '0;
        pos_d       = POSITION;
        dir_d       = DIR;
        err_d       = ERR;
        step        = STEP_NONE;

        case (state_q)
            PRIME: begin
                // Pending pin changes restart the settle count so the resting state is adopted, not counted
                if ((cur == prev_q) && a_quiet_c && b_quiet_c) begin
                    if (prime_cnt_q == FILTER_LEN - 4'd1) begin
                        state_d = RUN;
                    end else begin
                        prime_cnt_d = prime_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                step = quad_step(prev_q, cur);
                case (step)
                    STEP_FWD: begin
                        pos_d = POSITION + POS_WIDTH'(1);
                        dir_d = 1'b1;
                    end
                    STEP_REV: begin
                        pos_d = POSITION - POS_WIDTH'(1);
                        dir_d = 1'b0;
                    end
                    STEP_ILLEGAL: begin
                        err_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        endcase

        // Clear takes priority over a same-cycle count or error
        if (CLR) begin
            pos_d = '0;
            err_d = 1'b0;
        end
    end

    // Decoder state and position outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= PRIME;
            prev_q      <= S00;
            prime_cnt_q <= '0;
            POSITION    <= '0;
            DIR         <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prime_cnt_q <= prime_cnt_d;
            POSITION    <= pos_d;
            DIR         <= dir_d;
            ERR         <= err_d;
        end
    end

`ifdef QUAD_SPEED_EN
    localparam logic [POS_WIDTH-1:0] ACC_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic [POS_WIDTH-1:0] ACC_MIN = ~ACC_MAX + POS_WIDTH'(1);

    logic [WINDOW_WIDTH-1:0] win_q;
    logic [WINDOW_WIDTH-1:0] win_d;
    logic [POS_WIDTH-1:0]    acc_q;
    logic [POS_WIDTH-1:0]    acc_d;
    logic [POS_WIDTH-1:0]    acc_next;
    logic [POS_WIDTH-1:0]    speed_d;
    logic                    valid_d;

    // Speed gate: saturating accumulator latched into SPEED at the terminal count
    always_comb begin
        win_d    = '0;
        acc_d    = '0;
        acc_next = acc_q;
        speed_d  = SPEED;
        valid_d  = 1'b0;

        if (state_q == RUN) begin
            if ((step == STEP_FWD) && (acc_q != ACC_MAX)) begin
                acc_next = acc_q + POS_WIDTH'(1);
            end else if ((step == STEP_REV) && (acc_q != ACC_MIN)) begin
                acc_next = acc_q - POS_WIDTH'(1);
            end

            if (win_q == SPEED_WINDOW) begin
                speed_d = acc_next;
                valid_d = 1'b1;
            end else begin
                acc_d = acc_next;
                win_d = win_q + WINDOW_WIDTH'(1);
            end
        end
    end

    // Speed registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            win_q       <= '0;
            acc_q       <= '0;
            SPEED       <= '0;
            SPEED_VALID <= 1'b0;
        end else begin
            win_q       <= win_d;
            acc_q       <= acc_d;
            SPEED       <= speed_d;
            SPEED_VALID <= valid_d;
        end
    end
`else
    logic unused_speed_cfg;

    assign SPEED            = '0;
    assign SPEED_VALID      = 1'b0;
    assign unused_speed_cfg = ^SPEED_WINDOW;
`endif

endmodule
